// File: rtl/bus_responder.sv
// bus_responder: memory-mapped slave for a core's memory stage.
//   RAM (RAM_WORDS x 32) at 0x0000_0000, an output FIFO (FIFO_DEPTH entries)
//   with data/status registers at 0x1000_0000/0x1000_0004, and an optional
//   64-bit cycle counter (CYC_LO 0x1000_0008, CYC_HI 0x1000_000C).
// Optional feature macro: BUS_RESPONDER_CYCLE_COUNTER_EN (counter + shadow).
// Ports:
//   clk_i, reset_i (sync, active-high)
//   bus_addr_i/bus_wr_data_i/bus_wr_en_i  : bus request, every cycle is an access
//   bus_rd_data_o                         : combinational read data
//   out_data_o/out_valid_o/out_ready_i    : FIFO head, valid/ready handshake
//   decode_err_o                          : registered pulse for unmapped/misaligned
module bus_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wr_data_i,
  input  logic        bus_wr_en_i,
  output logic [31:0] bus_rd_data_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        decode_err_o
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;

  localparam logic [31:0] ADDR_FDATA  = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
  localparam logic [31:0] ADDR_CYC_LO = 32'h1000_0008;
  localparam logic [31:0] ADDR_CYC_HI = 32'h1000_000C;
`endif

  // Storage arrays: never reset
  logic [31:0] ram_q  [RAM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
  logic [63:0]   cyc_q, cyc_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          cyc_lo_hit, cyc_hi_hit;
`endif

  logic              aligned, ram_hit, fdata_hit, status_hit, mapped;
  logic [RAM_AW-1:0] ram_idx;
  logic              full, empty, pop, push_req, push;
  logic [31:0]       status_word;

  // Address decode; every mapped region requires word alignment
  always_comb begin
    aligned    = (bus_addr_i[1:0] == 2'b00);
    ram_hit    = aligned && (bus_addr_i < 32'(4 * RAM_WORDS));
    fdata_hit  = (bus_addr_i == ADDR_FDATA);
    status_hit = (bus_addr_i == ADDR_STATUS);
    ram_idx    = bus_addr_i[RAM_AW+1:2];
    mapped     = ram_hit | fdata_hit | status_hit;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
    cyc_lo_hit = (bus_addr_i == ADDR_CYC_LO);
    cyc_hi_hit = (bus_addr_i == ADDR_CYC_HI);
    mapped     = mapped | cyc_lo_hit | cyc_hi_hit;
`endif
  end

  // FIFO flags and handshake
  always_comb begin
    full        = (count_q == CW'(FIFO_DEPTH));
    empty       = (count_q == '0);
    pop         = valid_q && out_ready_i;
    push_req    = bus_wr_en_i && fdata_hit;
    // A full FIFO still accepts when the head leaves in the same cycle
    push        = push_req && (!full || pop);
    status_word = {23'd0, 5'(count_q), 1'b0, ovf_q, empty, full};
  end

  // Combinational read mux; FIFO_DATA and unmapped read as zero
  always_comb begin
    bus_rd_data_o = 32'd0;
    if (ram_hit)         bus_rd_data_o = ram_q[ram_idx];
    else if (status_hit) bus_rd_data_o = status_word;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
    else if (cyc_lo_hit) bus_rd_data_o = cyc_q[31:0];
    else if (cyc_hi_hit) bus_rd_data_o = shadow_q;
`endif
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    valid_d = (count_d != '0);
    // Overflow set wins over a same-cycle status-write clear
    ovf_d = (push_req && !push) || (ovf_q && !(bus_wr_en_i && status_hit));
    err_d = !mapped;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
    cyc_d    = cyc_q + 64'd1;
    shadow_d = shadow_q;
    // CYC_LO read snapshots the upper half so a later CYC_HI read is coherent
    if (!bus_wr_en_i && cyc_lo_hit) shadow_d = cyc_q[63:32];
`endif
  end

  // Control state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
      cyc_q    <= '0;
      shadow_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
      cyc_q    <= cyc_d;
      shadow_q <= shadow_d;
`endif
    end
  end

  // Storage writes; a push during reset lands in a slot the reset pointers ignore
  always_ff @(posedge clk_i) begin
    if (bus_wr_en_i && ram_hit) ram_q[ram_idx] <= bus_wr_data_i;
    if (push)                   fifo_q[wr_ptr_q] <= bus_wr_data_i;
  end

  assign out_data_o   = fifo_q[rd_ptr_q];
  assign out_valid_o  = valid_q;
  assign decode_err_o = err_q;

endmodule
